rc_settle_monitor: RTL and testbench

RC_SETTLE_MONITOR -- requirements
Module: rc_settle_monitor

---
 rtl/rc_settle_monitor.sv | 130 +++++++++++++
 tb/tb_rc_settle_monitor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rc_settle_monitor.sv
// Settle monitor for an RC model output: tracks consecutive in-band samples
// around TARGET and reports settle, timeout, or a post-settle glitch.
module rc_settle_monitor #(
  parameter int unsigned WIDTH          = 25,
  parameter int          TARGET         = 1000,
  parameter int unsigned TOL            = 10,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] v_in,
  output logic                    busy,
  output logic                    settled,
  output logic                    timeout,
  output logic                    glitch,
  output logic [15:0]             settle_cycles
);

  localparam int unsigned ERR_W = WIDTH + 2;
  localparam int unsigned CNT_W = 16;

  localparam logic [CNT_W-1:0]        HOLD_C    = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]        TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]        CNT_MAX   = {CNT_W{1'b1}};
  localparam logic signed [ERR_W-1:0] TARGET_E  = ERR_W'(TARGET);
  localparam logic signed [ERR_W-1:0] TOL_E     = ERR_W'(TOL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_SETTLED,
    ST_TIMEOUT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] elapsed_q, elapsed_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] settle_cycles_q, settle_cycles_d;
  logic             busy_q, busy_d;
  logic             settled_q, settled_d;
  logic             timeout_q, timeout_d;
  logic             glitch_q, glitch_d;

  logic signed [ERR_W-1:0] err_c;
  logic                    in_band_c;
  logic [CNT_W-1:0]        elapsed_inc_c;
  logic [CNT_W-1:0]        hold_inc_c;

  // Two guard bits keep the subtraction exact even for the most negative v_in.
  always_comb begin
    err_c     = ERR_W'(v_in) - TARGET_E;
    in_band_c = (err_c <= TOL_E) && (err_c >= -TOL_E);
  end

  always_comb begin
    elapsed_inc_c = (elapsed_q == CNT_MAX) ? elapsed_q : elapsed_q + CNT_W'(1);
    hold_inc_c    = (hold_q == CNT_MAX) ? hold_q : hold_q + CNT_W'(1);
  end

  // Next-state and counter update; a start pulse restarts from any non-TRACK state.
  always_comb begin
    state_d         = state_q;
    elapsed_d       = elapsed_q;
    hold_d          = hold_q;
    settle_cycles_d = settle_cycles_q;
    glitch_d        = glitch_q;

    case (state_q)
      ST_TRACK: begin
        elapsed_d = elapsed_inc_c;
        hold_d    = in_band_c ? hold_inc_c : '0;
        if (hold_d == HOLD_C) begin
          state_d         = ST_SETTLED;
          settle_cycles_d = elapsed_d;
        end else if (elapsed_d == TIMEOUT_C) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_SETTLED: begin
        if (!in_band_c) begin
          glitch_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (start && (state_q != ST_TRACK)) begin
      state_d         = ST_TRACK;
      elapsed_d       = '0;
      hold_d          = '0;
      glitch_d        = 1'b0;
      settle_cycles_d = '0;
    end

    busy_d    = (state_d == ST_TRACK);
    settled_d = (state_d == ST_SETTLED);
    timeout_d = (state_d == ST_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      elapsed_q       <= '0;
      hold_q          <= '0;
      settle_cycles_q <= '0;
      busy_q          <= 1'b0;
      settled_q       <= 1'b0;
      timeout_q       <= 1'b0;
      glitch_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      elapsed_q       <= elapsed_d;
      hold_q          <= hold_d;
      settle_cycles_q <= settle_cycles_d;
      busy_q          <= busy_d;
      settled_q       <= settled_d;
      timeout_q       <= timeout_d;
      glitch_q        <= glitch_d;
    end
  end

  assign busy          = busy_q;
  assign settled       = settled_q;
  assign timeout       = timeout_q;
  assign glitch        = glitch_q;
  assign settle_cycles = settle_cycles_q;

endmodule

// File: tb/tb_rc_settle_monitor.sv
// Directed bench for rc_settle_monitor with TARGET=1000, TOL=10, HOLD=4, TIMEOUT=32.
module tb_rc_settle_monitor;

  localparam int unsigned WIDTH = 25;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic signed [WIDTH-1:0] v_in;
  logic                    busy;
  logic                    settled;
  logic                    timeout;
  logic                    glitch;
  logic [15:0]             settle_cycles;

  int errors = 0;
  int checks = 0;

  rc_settle_monitor #(
    .WIDTH(WIDTH), .TARGET(1000), .TOL(10), .HOLD_CYCLES(4), .TIMEOUT_CYCLES(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .v_in(v_in),
    .busy(busy), .settled(settled), .timeout(timeout),
    .glitch(glitch), .settle_cycles(settle_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int b, input int s, input int t,
                         input int g, input int sc);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".settled"}, int'(settled), s);
    chk({tag, ".timeout"}, int'(timeout), t);
    chk({tag, ".glitch"}, int'(glitch), g);
    chk({tag, ".settle_cycles"}, int'(settle_cycles), sc);
    chk({tag, ".onehot"}, int'(busy) + int'(settled) + int'(timeout) <= 1, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Pulse start in cycle 0; returns at cycle 1 with start low.
  task automatic begin_meas();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; v_in = '0;

    // Reset state
    do_reset();
    chk_out("reset", 0, 0, 0, 0, 0);

    // Constant 1000, with an ignored start pulse mid-TRACK
    v_in = 25'sd1000;
    begin_meas();
    chk_out("const_c1", 1, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_out("const_c4", 1, 0, 0, 0, 0);
    tick();
    chk_out("const_c5", 0, 1, 0, 0, 4);

    // Glitch after settle, then restart clears it
    v_in = 25'sd1020;
    tick();
    chk_out("glitch_set", 0, 1, 0, 1, 4);
    v_in = 25'sd1000;
    tick();
    chk_out("glitch_sticky", 0, 1, 0, 1, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("restart_settled", 1, 0, 0, 0, 0);

    // Hold broken by 1011 at sample 4
    do_reset();
    begin_meas();
    for (int k = 1; k <= 8; k++) begin
      v_in = (k == 4) ? 25'sd1011 : 25'sd1000;
      if (k == 8) chk_out("break_c8", 1, 0, 0, 0, 0);
      tick();
    end
    chk_out("break_settle", 0, 1, 0, 0, 8);

    // Constant 0 -> timeout after 32 samples
    do_reset();
    v_in = '0;
    begin_meas();
    for (int k = 1; k <= 31; k++) tick();
    chk_out("zero_c31", 1, 0, 0, 0, 0);
    tick();
    chk_out("zero_timeout", 0, 0, 1, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("restart_timeout", 1, 0, 0, 0, 0);

    // Alternating band edges 990/1010 settle in 4
    do_reset();
    begin_meas();
    for (int k = 1; k <= 4; k++) begin
      v_in = k[0] ? 25'sd990 : 25'sd1010;
      tick();
    end
    chk_out("edges_settle", 0, 1, 0, 0, 4);

    // 989 just outside band -> timeout
    do_reset();
    v_in = 25'sd989;
    begin_meas();
    for (int k = 1; k <= 32; k++) tick();
    chk_out("below_timeout", 0, 0, 1, 0, 0);

    // Reset mid-TRACK at sample 2
    do_reset();
    v_in = 25'sd1000;
    begin_meas();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("rst_track", 0, 0, 0, 0, 0);
    tick();
    chk_out("rst_track_idle", 0, 0, 0, 0, 0);

    // Reset wins over start while SETTLED
    begin_meas();
    for (int k = 1; k <= 4; k++) tick();
    chk_out("pre_rst_settled", 0, 1, 0, 0, 4);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk_out("rst_over_start", 0, 0, 0, 0, 0);

    // Most negative input is out of band without wrap
    v_in = {1'b1, {(WIDTH-1){1'b0}}};
    begin_meas();
    for (int k = 1; k <= 31; k++) tick();
    chk_out("minneg_c31", 1, 0, 0, 0, 0);
    tick();
    chk_out("minneg_timeout", 0, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
